// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the dual-issue fetch stage
package fetch_pkg;

  localparam logic [31:0] NOP_E = 32'h4020_0000;
  localparam logic [31:0] NOP_O = 32'h0020_0000;

  typedef struct packed {
    logic [31:0] instr1;
    logic [31:0] instr2;
    logic [31:0] pc;
  } fetch_pair_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_pair_fifo.sv
// rtl/fetch_pair_fifo.sv - pair buffer with wrap-bit pointers and synchronous flush
module fetch_pair_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_pair_t              i_data,
  output fetch_pair_t              o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  fetch_pair_t r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_wr;
  logic        w_rd;

  assign o_count = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign w_wr    = i_push & ~o_full & ~i_flush;
  assign w_rd    = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + ONE;
      if (w_rd) r_rptr <= r_rptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - dual-issue fetch: credit-limited pair prefetch, hold on Wait/Stall, redirect on Flush
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MEM_LAT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Flush,
  input  logic [0:31] BranchTarget,
  input  logic        Stall,
  input  logic        Wait,
  input  logic        done,
  output logic        InstrReq,
  output logic [0:31] InstrAddr,
  input  logic [0:63] InstrData,
  output logic [0:31] Instruction1,
  output logic [0:31] Instruction2,
  output logic [0:31] PCIn
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t             r_state;
  fetch_state_t             w_state_nxt;
  logic [31:0]              r_fetch_pc;
  logic [31:0]              r_exp_pc;
  logic [31:0]              r_addr;
  logic                     r_req;
  logic                     r_skip;
  logic [MEM_LAT-1:0]       r_vld;
  logic [MEM_LAT-1:0][31:0] r_tag;

  logic                     w_clear;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_req_nxt;
  logic                     w_empty;
  logic                     w_full;
  logic [CW-1:0]            w_count;
  logic [7:0]               w_inflight;
  logic [7:0]               w_used;
  logic [31:0]              w_target;
  logic                     w_unused_bt;
  fetch_pair_t              w_in;
  fetch_pair_t              w_head;

  assign w_target    = {BranchTarget[0:28], 3'b000};
  assign w_unused_bt = &{1'b0, BranchTarget[30:31]};
  assign w_clear     = Flush | done;
  assign w_pop       = ~w_empty & ~Stall & ~Wait & ~w_clear;
  assign w_push      = r_vld[MEM_LAT-1] & ~w_clear & ~w_full;
  assign w_in        = '{instr1: InstrData[0:31], instr2: InstrData[32:63], pc: r_tag[MEM_LAT-1]};

  // The request being presented plus every pending response holds a buffer slot.
  always_comb begin
    w_inflight = {7'd0, r_req};
    for (int i = 0; i < MEM_LAT; i++) w_inflight = w_inflight + {7'd0, r_vld[i]};
  end

  assign w_used    = 8'(w_count) - {7'd0, w_pop} + w_inflight;
  assign w_req_nxt = (r_state == RUN) & ~w_clear & (w_used < 8'(DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    if (done)       w_state_nxt = HALT;
    else if (Flush) w_state_nxt = RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_fetch_pc <= RESET_PC;
      r_exp_pc   <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
      r_skip     <= 1'b0;
      r_vld      <= '0;
      r_tag      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        r_vld[i] <= r_vld[i-1] & ~w_clear;
        r_tag[i] <= r_tag[i-1];
      end
      r_vld[0] <= r_req & ~w_clear;
      r_tag[0] <= r_addr;
      if (done) begin
        r_skip <= 1'b0;
      end else if (Flush) begin
        r_fetch_pc <= w_target;
        r_exp_pc   <= w_target;
        r_skip     <= BranchTarget[29];
      end else begin
        if (w_req_nxt) begin
          r_addr     <= r_fetch_pc;
          r_fetch_pc <= r_fetch_pc + 32'd8;
        end
        if (w_pop) begin
          r_exp_pc <= r_exp_pc + 32'd8;
          r_skip   <= 1'b0;
        end
      end
    end
  end

  fetch_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_clear),
    .i_data  (w_in),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_comb begin
    Instruction1 = NOP_E;
    Instruction2 = NOP_O;
    PCIn         = r_exp_pc;
    if (!w_empty) begin
      Instruction1 = r_skip ? NOP_E : w_head.instr1;
      Instruction2 = w_head.instr2;
      PCIn         = w_head.pc;
    end
  end

  assign InstrReq  = r_req;
  assign InstrAddr = r_addr;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - fetch_stage bench: reset table, corner sequences, randomized run against a queue model
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          MEM_LAT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, Flush, Stall, Wait, done, InstrReq;
  logic [0:31] BranchTarget, InstrAddr, Instruction1, Instruction2, PCIn;
  logic [0:63] InstrData;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  fetch_stage #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .Flush(Flush), .BranchTarget(BranchTarget),
    .Stall(Stall), .Wait(Wait), .done(done), .InstrReq(InstrReq),
    .InstrAddr(InstrAddr), .InstrData(InstrData), .Instruction1(Instruction1),
    .Instruction2(Instruction2), .PCIn(PCIn)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h9E37_0000 ^ {a[15:0], 16'h0000};
  endfunction

  // Memory: fixed-latency pipe; returns garbage when no response is due.
  logic [MEM_LAT-1:0] mp_v = '0;
  logic [31:0]        mp_a [MEM_LAT];
  always @(posedge clk) begin
    mp_v[0] <= InstrReq;
    mp_a[0] <= InstrAddr;
    for (int i = 1; i < MEM_LAT; i++) begin
      mp_v[i] <= mp_v[i-1];
      mp_a[i] <= mp_a[i-1];
    end
  end
  always_comb begin
    InstrData = 64'hDEAD_BEEF_DEAD_BEEF;
    if (mp_v[MEM_LAT-1])
      InstrData = {mem_word(mp_a[MEM_LAT-1]), mem_word(mp_a[MEM_LAT-1] + 32'd4)};
  end

  typedef struct { logic [31:0] addr; int due; } fly_t;
  fly_t        q_fly[$];
  logic [31:0] q_buf[$];
  bit          m_halt, m_req, m_skip;
  logic [31:0] m_reqaddr, m_fetch, m_exp;

  typedef struct { bit stall; bit req; logic [31:0] addr; logic [31:0] pc; bit bub; } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    q_fly.delete();
    q_buf.delete();
    m_halt = 0; m_req = 0; m_skip = 0;
    m_reqaddr = RESET_PC; m_fetch = RESET_PC; m_exp = RESET_PC;
  endtask

  task automatic check_model();
    logic [31:0] pc, e1, e2;
    chk("req", 32'(InstrReq), 32'(m_req));
    if (m_req) chk("addr", InstrAddr, m_reqaddr);
    if (q_buf.size() == 0) begin
      pc = m_exp; e1 = NOP_E; e2 = NOP_O;
    end else begin
      pc = q_buf[0];
      e1 = m_skip ? NOP_E : mem_word(pc);
      e2 = mem_word(pc + 32'd4);
    end
    chk("instr1", Instruction1, e1);
    chk("instr2", Instruction2, e2);
    chk("pcin", PCIn, pc);
    chk("credit_overflow", 32'(dut.r_vld[MEM_LAT-1] & dut.w_full), 32'd0);
  endtask

  // One clock of the spec's rules applied to queues of outstanding and buffered pairs.
  task automatic model_update();
    bit          clr, pop, nreq;
    int          used;
    logic [31:0] bt;
    fly_t        f;
    bt  = BranchTarget;
    clr = Flush | done;
    if (m_req) begin
      f.addr = m_reqaddr;
      f.due  = cyc + MEM_LAT;
      q_fly.push_back(f);
    end
    pop  = (q_buf.size() != 0) && !Stall && !Wait && !clr;
    used = q_buf.size() - int'(pop) + q_fly.size();
    nreq = !m_halt && !clr && (used < DEPTH);
    if (clr) begin
      q_buf.delete();
      q_fly.delete();
      m_skip = 0;
      if (done) m_halt = 1;
      else begin
        m_halt  = 0;
        m_fetch = bt & ~32'h7;
        m_exp   = m_fetch;
        m_skip  = bt[2];
      end
    end else begin
      if (pop) begin
        void'(q_buf.pop_front());
        m_exp  = m_exp + 32'd8;
        m_skip = 0;
      end
      while (q_fly.size() != 0 && q_fly[0].due == cyc) begin
        q_buf.push_back(q_fly[0].addr);
        void'(q_fly.pop_front());
      end
      chk("buf_depth", 32'(q_buf.size() > DEPTH), 32'd0);
      if (nreq) begin
        m_reqaddr = m_fetch;
        m_fetch   = m_fetch + 32'd8;
      end
    end
    m_req = nreq;
    cyc++;
  endtask

  task automatic drive(input bit f, input logic [31:0] bt, input bit s, input bit w, input bit d);
    Flush = f; BranchTarget = bt; Stall = s; Wait = w; done = d;
  endtask

  task automatic sample();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit s, input bit w);
    for (int i = 0; i < n; i++) begin
      drive(0, 32'd0, s, w, 0);
      sample();
      advance();
    end
  endtask

  initial begin
    tbl[0] = '{1, 0, 32'd0,  32'd0, 1};
    tbl[1] = '{1, 1, 32'd0,  32'd0, 1};
    tbl[2] = '{1, 1, 32'd8,  32'd0, 1};
    tbl[3] = '{1, 1, 32'd16, 32'd0, 1};
    tbl[4] = '{1, 1, 32'd24, 32'd0, 0};
    tbl[5] = '{1, 0, 32'd0,  32'd0, 0};
    tbl[6] = '{1, 0, 32'd0,  32'd0, 0};
    tbl[7] = '{1, 0, 32'd0,  32'd0, 0};

    reset = 1'b1;
    drive(0, 32'd0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(InstrReq), 32'd0);
    chk("rst_addr", InstrAddr, RESET_PC);
    chk("rst_i1", Instruction1, NOP_E);
    chk("rst_i2", Instruction2, NOP_O);
    chk("rst_pc", PCIn, 32'd0);
    reset = 1'b0;
    model_reset();

    // Reset release with decode stalled: four requests then credits run out.
    for (int i = 0; i < 8; i++) begin
      drive(0, 32'd0, tbl[i].stall, 0, 0);
      @(negedge clk);
      check_model();
      chk("tbl_req", 32'(InstrReq), 32'(tbl[i].req));
      if (tbl[i].req) chk("tbl_addr", InstrAddr, tbl[i].addr);
      chk("tbl_pc", PCIn, tbl[i].pc);
      chk("tbl_i1", Instruction1, tbl[i].bub ? NOP_E : mem_word(tbl[i].pc));
      chk("tbl_i2", Instruction2, tbl[i].bub ? NOP_O : mem_word(tbl[i].pc + 32'd4));
      advance();
    end

    run(12, 0, 0);

    // Wait held for two cycles while pair 16 is at the head.
    drive(1, 32'd0, 0, 0, 0);
    sample();
    advance();
    run(6, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 32'd0, 0, k < 2, 0);
      sample();
      chk("wait_pc", PCIn, (k < 3) ? 32'd16 : 32'd24);
      advance();
    end

    // Flush to 0x104 with requests outstanding.
    run(3, 0, 0);
    drive(1, 32'h104, 0, 0, 0);
    sample();
    advance();
    for (int k = 1; k <= 6; k++) begin
      drive(0, 32'd0, 0, 0, 0);
      sample();
      if (k == 1) chk("flush_req_off", 32'(InstrReq), 32'd0);
      if (k == 2) begin
        chk("flush_req_on", 32'(InstrReq), 32'd1);
        chk("flush_addr", InstrAddr, 32'h100);
      end
      if (k == 5) begin
        chk("skip_pc", PCIn, 32'h100);
        chk("skip_i1", Instruction1, NOP_E);
        chk("skip_i2", Instruction2, mem_word(32'h104));
      end
      if (k == 6) begin
        chk("after_skip_pc", PCIn, 32'h108);
        chk("after_skip_i1", Instruction1, mem_word(32'h108));
      end
      advance();
    end

    // done with Flush: halt wins.
    drive(1, 32'h40, 0, 0, 1);
    sample();
    advance();
    for (int k = 0; k < 8; k++) begin
      drive(0, 32'd0, 0, 0, 0);
      sample();
      chk("halt_req", 32'(InstrReq), 32'd0);
      chk("halt_i1", Instruction1, NOP_E);
      chk("halt_i2", Instruction2, NOP_O);
      advance();
    end

    // Flush out of HALT near the top of the address space to exercise wrap.
    drive(1, 32'hFFFF_FFEC, 0, 0, 0);
    sample();
    advance();
    run(12, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] bt;
      bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1C))
                                       : ($urandom & 32'hFFFF_FFFC);
      drive($urandom_range(0, 19) == 0, bt, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0);
      sample();
      advance();
    end

    // Asynchronous reset in the middle of a burst.
    drive(1, 32'h200, 0, 0, 0);
    sample();
    advance();
    run(5, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_req", 32'(InstrReq), 32'd0);
    chk("areset_i1", Instruction1, NOP_E);
    chk("areset_i2", Instruction2, NOP_O);
    chk("areset_pc", PCIn, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    run(10, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
